input_debouncer: RTL and testbench
==================================

// Module: input_debouncer
// PURPOSE
//  Cleans a raw, asynchronous, bouncy input (button/switch/pin) into a glitch-free level.
//  - Synchronises din into clk, then requires STABLE_CNT consecutive qualifying ticks of the
//    new value before dout follows.
//  - Sits directly upstream of the transition-detector FSM: dout drives that FSM's i input.
//  - Also provides registered 1-cycle rise/fall pulses.
// PARAMETERS
//  SYNC_STAGES  2   synchroniser depth; legal >= 2
//  STABLE_CNT   4   consecutive ticks of stable level needed to accept a change; legal >= 1
//  CNT_W        $clog2(STABLE_CNT+1)  counter width; localparam, derived, not overridable
// PORTS
//  clk    in   1      clock, rising edge
//  rst    in   1      reset, asynchronous, active-low
//  din    in   1      raw asynchronous input
//  tick   in   1      sample enable; tie 1 to count every clk, or drive from a prescaler
//  dout   out  1      debounced level
//  rise   out  1      1-cycle pulse, first cycle dout=1
//  fall   out  1      1-cycle pulse, first cycle dout=0
//  busy   out  1      1 while a change is being qualified (S_LO2HI / S_HI2LO)
// BEHAVIOUR
//  Reset (rst=0, async): sync chain=0, state=S_LO, cnt=0, dout=0, rise=0, fall=0, busy=0.
//    Reset overrides any in-progress qualification.
//    Afterwards a high din must be fully re-qualified; no rise pulse occurs during reset.
//  Sync: din_s = last stage of the SYNC_STAGES flop chain; only din_s is used downstream.
//  FSM states and transitions:
//    S_LO     dout=0: din_s=1 -> S_LO2HI, cnt<=0.
//    S_LO2HI  dout=0, busy=1:
//             - din_s=0 (any cycle, tick ignored) -> S_LO, cnt<=0; abort, no pulse.
//             - tick & din_s=1 & cnt==STABLE_CNT-1 -> S_HI.
//             - tick & din_s=1 otherwise -> cnt<=cnt+1.
//             - tick=0 & din_s=1 -> hold state and cnt.
//    S_HI     dout=1: din_s=0 -> S_HI2LO, cnt<=0.
//    S_HI2LO  dout=1, busy=1: mirror of S_LO2HI with polarities swapped; completes to S_LO.
//    Illegal/unused encodings -> S_LO.
//  Outputs:
//    - dout, busy, rise, fall are all registered; no combinational path from din.
//    - rise=1 for exactly the one cycle following the S_LO2HI->S_HI edge; fall likewise for S_HI2LO->S_LO.
//    - rise and fall are never 1 in the same cycle.
//  Latency (tick=1): a din change first sampled on clk edge E1 appears on dout after edge
//    E(SYNC_STAGES+STABLE_CNT+1). Defaults: 7th edge.
//    With tick gated, add the cycles spent waiting for ticks.
//  Boundaries:
//    - STABLE_CNT=1: one qualifying tick suffices.
//    - cnt never exceeds STABLE_CNT-1; no wrap.
//    - Bounce shorter than qualification produces no dout change and no pulse.
//    - din toggling every cycle holds dout at its current value indefinitely.
//    - din_s returning to the current dout value mid-count aborts even when tick=0.
// STRUCTURE
//  debounce_pkg: state encoding localparams S_LO=2'b00, S_LO2HI=2'b01, S_HI=2'b11, S_HI2LO=2'b10.
//  Sub-module sync_chain #(STAGES): N-flop synchroniser with async active-low clear to 0.
//  Top: sync_chain instance, state reg, cnt reg, next-state always @*, registered outputs.
// TESTING
//  1 rst=0 with din=1 -> dout=0, rise=0, fall=0, busy=0.
//    Release, din=1 held, tick=1 -> dout=1 on 7th edge; rise=1 one cycle; busy=1 for 4 cycles before.
//  2 din=1 for 3 cycles then 0, tick=1 -> dout stays 0, rise never 1, state back to S_LO.
//  3 tick=1 every 4th clk, din 0->1 held -> dout rises after 4 ticks, i.e. qualification ~16 clks; counter frozen between ticks.
//  4 From dout=1, din=0 held -> dout=0 on 7th edge, fall pulses once, rise stays 0.
//  5 rst asserted while S_LO2HI with cnt=2 -> dout/busy/rise=0 immediately (async).
//    After release with din=1 still held -> full 7-edge qualification before dout=1.
//  6 din toggles every clk for 50 cycles -> dout, rise, fall constant 0; then din=1 stable -> normal rise.

Source files
------------

// File: rtl/input_debouncer_pkg.sv
// Package for the input debouncer.
// Holds the FSM state encoding shared by the top and the bench.
// The encoding is chosen so that bit[1] is the debounced level and
// bit[1]^bit[0] marks a qualification in progress.
package input_debouncer_pkg;

  typedef enum logic [1:0] {
    S_LO    = 2'b00,
    S_LO2HI = 2'b01,
    S_HI2LO = 2'b10,
    S_HI    = 2'b11
  } state_e;

endpackage

// File: rtl/input_debouncer_if.sv
// Interface for the input debouncer.
// Signals:
//   din   raw asynchronous input       (master -> slave)
//   tick  sample enable                (master -> slave)
//   dout  debounced level              (slave -> master)
//   rise  1-cycle pulse, dout 0->1     (slave -> master)
//   fall  1-cycle pulse, dout 1->0     (slave -> master)
//   busy  change being qualified       (slave -> master)
interface input_debouncer_if;
  logic din;
  logic tick;
  logic dout;
  logic rise;
  logic fall;
  logic busy;

  modport master (output din, tick, input dout, rise, fall, busy);
  modport slave  (input din, tick, output dout, rise, fall, busy);
endinterface

// File: rtl/input_debouncer_sync_chain.sv
// N-flop synchroniser with asynchronous active-low clear to 0.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-low clear
//   i_d  asynchronous input
//   o_q  synchronised output (last stage)
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sync <= '0;
    else      r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debouncer: synchronises a bouncy raw input, then requires STABLE_CNT
// consecutive ticks of a new level before the debounced output follows.
// Provides registered rise/fall pulses and a busy flag.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-low reset
//   bus  input_debouncer_if.slave: din, tick in; dout, rise, fall, busy out
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input_debouncer_if.slave    bus
);

  localparam int               CNT_W   = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

  logic             w_din_s;
  state_e           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic             r_dout, r_rise, r_fall, r_busy;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.din),
    .o_q (w_din_s)
  );

  // A din_s back at the current level aborts regardless of tick; only
  // qualifying ticks advance the counter.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      S_LO: if (w_din_s) begin
        w_state_nx = S_LO2HI;
        w_cnt_nx   = '0;
      end
      S_LO2HI: begin
        if (!w_din_s) begin
          w_state_nx = S_LO;
          w_cnt_nx   = '0;
        end else if (bus.tick) begin
          if (r_cnt == CNT_MAX) begin
            w_state_nx = S_HI;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      S_HI: if (!w_din_s) begin
        w_state_nx = S_HI2LO;
        w_cnt_nx   = '0;
      end
      S_HI2LO: begin
        if (w_din_s) begin
          w_state_nx = S_HI;
          w_cnt_nx   = '0;
        end else if (bus.tick) begin
          if (r_cnt == CNT_MAX) begin
            w_state_nx = S_LO;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = S_LO;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in the same
  // cycle as the state they describe, while still coming from flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_LO;
      r_cnt   <= '0;
      r_dout  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_dout  <= w_state_nx[1];
      r_busy  <= w_state_nx[1] ^ w_state_nx[0];
      r_rise  <= (r_state == S_LO2HI) && (w_state_nx == S_HI);
      r_fall  <= (r_state == S_HI2LO) && (w_state_nx == S_LO);
    end
  end

  assign bus.dout = r_dout;
  assign bus.rise = r_rise;
  assign bus.fall = r_fall;
  assign bus.busy = r_busy;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: two instances (STABLE_CNT=4 and 1) share
// din/tick; a per-instance reference model tracks the expected outputs.
module tb_input_debouncer;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic tick = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  input_debouncer_if bus0 ();
  input_debouncer_if bus1 ();
  assign bus0.din  = din;
  assign bus0.tick = tick;
  assign bus1.din  = din;
  assign bus1.tick = tick;

  input_debouncer #(.SYNC_STAGES(SYNC), .STABLE_CNT(4)) u0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  input_debouncer #(.SYNC_STAGES(SYNC), .STABLE_CNT(1)) u1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  // Reference: delay din by the synchroniser depth, then count ticks seen
  // while the synchronised value differs from the accepted level. The edge
  // that first sees a difference only opens the window; STABLE ticks after
  // that accept the new level.
  typedef struct {
    bit [SYNC-1:0] sh;
    bit            pend;
    int            run;
    bit            dout;
    bit            rise;
    bit            fall;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mstep(mdl_t m, bit d, bit t, int stable);
    mdl_t n;
    bit   ds;
    n      = m;
    ds     = m.sh[SYNC-1];
    n.rise = 0;
    n.fall = 0;
    n.sh   = {m.sh[SYNC-2:0], d};
    if (ds == m.dout) begin
      n.pend = 0;
      n.run  = 0;
    end else if (!m.pend) begin
      n.pend = 1;
      n.run  = 0;
    end else if (t) begin
      if (m.run + 1 == stable) begin
        n.dout = ds;
        n.pend = 0;
        n.run  = 0;
        n.rise = ds;
        n.fall = !ds;
      end else begin
        n.run = m.run + 1;
      end
    end
    return n;
  endfunction

  function automatic mdl_t mreset();
    mdl_t n;
    n.sh = '0; n.pend = 0; n.run = 0; n.dout = 0; n.rise = 0; n.fall = 0;
    return n;
  endfunction

  task automatic chk(string nm, logic a, logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @%0t: got %0b want %0b", nm, $time, a, e);
    end
  endtask

  task automatic chk_model();
    chk("u0.dout", bus0.dout, m0.dout);
    chk("u0.rise", bus0.rise, m0.rise);
    chk("u0.fall", bus0.fall, m0.fall);
    chk("u0.busy", bus0.busy, m0.pend);
    chk("u1.dout", bus1.dout, m1.dout);
    chk("u1.rise", bus1.rise, m1.rise);
    chk("u1.fall", bus1.fall, m1.fall);
    chk("u1.busy", bus1.busy, m1.pend);
    chk("u0.rise&fall", bus0.rise & bus0.fall, 1'b0);
  endtask

  // Called 1 time unit after a posedge: drive, clock once, advance models, check.
  task automatic step(bit d, bit t);
    din  = d;
    tick = t;
    @(posedge clk);
    m0 = mstep(m0, d, t, 4);
    m1 = mstep(m1, d, t, 1);
    #1;
    chk_model();
  endtask

  typedef struct {
    bit din; bit tick;
    bit dout; bit rise; bit fall; bit busy;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Rise after reset with din held high, then fall with din held low.
    for (int i = 1; i <= 8; i++)
      tbl.push_back('{1, 1, i >= 7, i == 7, 0, i >= 3 && i <= 6});
    for (int i = 1; i <= 8; i++)
      tbl.push_back('{0, 1, i < 7, 0, i == 7, i >= 3 && i <= 6});

    m0 = mreset();
    m1 = mreset();

    // Reset held with din=1: nothing may move.
    din = 1; tick = 1; rst = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.dout", bus0.dout, 1'b0);
    chk("rst.rise", bus0.rise, 1'b0);
    chk("rst.fall", bus0.fall, 1'b0);
    chk("rst.busy", bus0.busy, 1'b0);
    chk("rst.u1dout", bus1.dout, 1'b0);
    rst = 1;

    foreach (tbl[k]) begin
      step(tbl[k].din, tbl[k].tick);
      chk($sformatf("tbl%0d.dout", k), bus0.dout, tbl[k].dout);
      chk($sformatf("tbl%0d.rise", k), bus0.rise, tbl[k].rise);
      chk($sformatf("tbl%0d.fall", k), bus0.fall, tbl[k].fall);
      chk($sformatf("tbl%0d.busy", k), bus0.busy, tbl[k].busy);
    end

    // Short bounce: 3 cycles high is too short for STABLE_CNT=4.
    repeat (3) step(1, 1);
    repeat (8) step(0, 1);
    chk("bounce.dout", bus0.dout, 1'b0);
    chk("bounce.busy", bus0.busy, 1'b0);

    // Tick every 4th clock: qualification stretches, counter frozen between.
    for (int i = 0; i < 24; i++) begin
      step(1, (i % 4) == 3);
      if (i == 8) chk("slowtick.early", bus0.dout, 1'b0);
    end
    chk("slowtick.dout", bus0.dout, 1'b1);
    repeat (10) step(0, 1);

    // Async reset mid-qualification (u0 at cnt=2, u1 already high).
    repeat (5) step(1, 1);
    chk("pre_rst.busy", bus0.busy, 1'b1);
    #2 rst = 0;
    #1;
    chk("arst.dout", bus0.dout, 1'b0);
    chk("arst.busy", bus0.busy, 1'b0);
    chk("arst.rise", bus0.rise, 1'b0);
    chk("arst.u1dout", bus1.dout, 1'b0);
    @(posedge clk);
    #1;
    chk("arst.hold", bus0.busy, 1'b0);
    rst = 1;
    m0 = mreset();
    m1 = mreset();
    for (int i = 1; i <= 8; i++) begin
      step(1, 1);
      if (i == 6) chk("rearm.e6", bus0.dout, 1'b0);
      if (i == 7) chk("rearm.e7", bus0.dout, 1'b1);
    end
    repeat (8) step(0, 1);

    // Toggle every cycle: level must never move.
    for (int i = 0; i < 50; i++) begin
      step(i[0], 1);
      chk("toggle.dout", bus0.dout, 1'b0);
      chk("toggle.u1dout", bus1.dout, 1'b0);
    end
    repeat (10) step(1, 1);
    chk("toggle.after", bus0.dout, 1'b1);

    // Random bursts with random hold lengths and gated ticks.
    for (int b = 0; b < 300; b++) begin
      bit d;
      int len;
      d   = $urandom_range(0, 1);
      len = $urandom_range(1, 12);
      for (int j = 0; j < len; j++) step(d, $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
